// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: stage count,
// parameter sanity check and the per-stage control record.
package csa_pkg;

   // Control part of a pipeline stage record; the skewed operand and partial
   // sum vectors are width-dependent and live next to it in csa_pipe.
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctrl_t;

   // Number of registered stages; clamped to 1 so a bad parameter set still
   // elaborates far enough to report the width error.
   function automatic int unsigned num_stages(input int unsigned n, input int unsigned m,
                                              input int unsigned b);
      if ((m * b) == 0 || n < (m * b)) return 1;
      return n / (m * b);
   endfunction

   function automatic bit width_ok(input int unsigned n, input int unsigned m,
                                   input int unsigned b);
      return (n != 0) && (m != 0) && (b != 0) && ((n % (m * b)) == 0);
   endfunction

endpackage

// File: rtl/csa_blk.sv
// M-bit dual-carry block: both sums are precomputed, sel picks one.
module csa_blk
   import csa_pkg::*;
#(
   parameter int unsigned M = 4
) (
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   input  logic         sel,
   output logic [M-1:0] s,
   output logic         c0,
   output logic         c1
);

   logic [M-1:0] s0;
   logic [M-1:0] s1;

   // Carry-in 0 and carry-in 1 sums, then select by the incoming block carry.
   always_comb begin
      {c0, s0} = {1'b0, a} + {1'b0, b};
      {c1, s1} = {1'b0, a} + {1'b0, b} + (M + 1)'(1);
      s        = sel ? s1 : s0;
   end

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor with a global-stall valid/ready
// handshake. Rank r holds the operation waiting to resolve stage r; the output
// register is the final rank, so latency is S cycles.
module csa_pipe
   import csa_pkg::*;
#(
   parameter int unsigned N = 256,
   parameter int unsigned M = 4,
   parameter int unsigned B = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned W  = M * B;
   localparam int unsigned S  = num_stages(N, M, B);
   localparam int unsigned NB = N / M;

   if (!width_ok(N, M, B)) begin : g_bad_width
      $error("csa_pipe: N must be a nonzero multiple of M*B");
   end

   logic stall;

   // Per rank: below r*W the vector already holds resolved sum bits, above it
   // still holds operand a. b_q carries b_eff for the unresolved part.
   stage_ctrl_t  ctrl_q [S];
   stage_ctrl_t  ctrl_d [S];
   logic [N-1:0] as_q   [S];
   logic [N-1:0] as_d   [S];
   logic [N-1:0] b_q    [S];
   logic [N-1:0] b_d    [S];

   logic [N-1:0]  blk_s;
   logic [NB-1:0] blk_c0;
   logic [NB-1:0] blk_c1;
   logic [NB-1:0] blk_cin;
   logic [S-1:0]  stage_cout;
   logic [N-1:0]  final_s;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Dual-carry blocks; block j belongs to stage j/B and reads that rank.
   for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int unsigned R = j / B;
      csa_blk #(
         .M (M)
      ) u_blk (
         .a   (as_q[R][j*M +: M]),
         .b   (b_q[R][j*M +: M]),
         .sel (blk_cin[j]),
         .s   (blk_s[j*M +: M]),
         .c0  (blk_c0[j]),
         .c1  (blk_c1[j])
      );
   end

   // Combinational select chain across the B blocks of each stage, seeded by
   // that rank's registered carry.
   always_comb begin
      logic c;
      c          = 1'b0;
      blk_cin    = '0;
      stage_cout = '0;
      for (int r = 0; r < S; r++) begin
         c = ctrl_q[r].carry;
         for (int k = 0; k < B; k++) begin
            blk_cin[r*B + k] = c;
            c = blk_c0[r*B + k] | (blk_c1[r*B + k] & c);
         end
         stage_cout[r] = c;
      end
   end

   // Next rank contents: operand conditioning into rank 0, then each rank
   // merges in the W sum bits its stage just resolved.
   always_comb begin
      ctrl_d[0].valid = in_valid;
      ctrl_d[0].carry = sub | cin;
      as_d[0]         = a;
      b_d[0]          = sub ? ~b : b;
      for (int r = 1; r < S; r++) begin
         ctrl_d[r].valid         = ctrl_q[r-1].valid;
         ctrl_d[r].carry         = stage_cout[r-1];
         as_d[r]                 = as_q[r-1];
         as_d[r][(r-1)*W +: W]   = blk_s[(r-1)*W +: W];
         b_d[r]                  = b_q[r-1];
      end
   end

   // Rank valid/carry registers; only the valids need a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < S; r++) ctrl_q[r].valid <= 1'b0;
      end else if (!stall) begin
         ctrl_q <= ctrl_d;
      end
   end

   // Skewed operand / partial sum registers, frozen with the rest on a stall.
   always_ff @(posedge clk) begin
      if (!stall) begin
         as_q <= as_d;
         b_q  <= b_d;
      end
   end

   // Full result as seen by the last stage.
   always_comb begin
      final_s                   = as_q[S-1];
      final_s[(S-1)*W +: W]     = blk_s[(S-1)*W +: W];
   end

   // Output rank; data only loads on a valid op so bubbles leave it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         out_valid <= ctrl_q[S-1].valid;
         if (ctrl_q[S-1].valid) begin
            s    <= final_s;
            cout <= stage_cout[S-1];
            ovf  <= (as_q[S-1][N-1] == b_q[S-1][N-1]) && (final_s[N-1] != as_q[S-1][N-1]);
         end
      end
   end

endmodule

// File: tb/tb_csa_pipe.sv
// Bench for csa_pipe: reference model queue plus directed vectors.
module tb_csa_pipe;

   localparam int unsigned N = 256;
   localparam int unsigned M = 4;
   localparam int unsigned B = 16;
   localparam int unsigned S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] s;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [N-1:0] s;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   nres       = 0;

   always #5 clk = ~clk;

   csa_pipe #(
      .N (N),
      .M (M),
      .B (B)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Plain (N+1)-bit arithmetic reference.
   function automatic exp_t model(input logic [N-1:0] va, input logic [N-1:0] vb,
                                  input logic vc, input logic vs);
      exp_t         r;
      logic [N:0]   t;
      logic [N-1:0] be;
      be     = vs ? ~vb : vb;
      t      = {1'b0, va} + {1'b0, be} + {{N{1'b0}}, (vs ? 1'b1 : vc)};
      r.s    = t[N-1:0];
      r.cout = t[N];
      r.ovf  = (va[N-1] == be[N-1]) && (t[N-1] != va[N-1]);
      return r;
   endfunction

   // Scoreboard: push on accept, compare the head whenever out_valid is up.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         check("in_ready_rule", (N+1)'(in_ready), (N+1)'(!(out_valid && !out_ready)));
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_result", (N+1)'(out_valid), (N+1)'(0));
            end else begin
               check("model_s", (N+1)'(s), (N+1)'(q[0].s));
               check("model_cout", (N+1)'(cout), (N+1)'(q[0].cout));
               check("model_ovf", (N+1)'(ovf), (N+1)'(q[0].ovf));
               if (out_ready) begin
                  void'(q.pop_front());
                  nres++;
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      end
   end

   // One op into an idle pipe; checks latency and hand-computed results.
   task automatic do_single(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                            input logic vc, input logic vs, input logic [N-1:0] es,
                            input logic ec, input logic eo);
      int n;
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, (N+1)'(n), (N+1)'(S));
      check({name, "_s"}, (N+1)'(s), (N+1)'(es));
      check({name, "_cout"}, (N+1)'(cout), (N+1)'(ec));
      check({name, "_ovf"}, (N+1)'(ovf), (N+1)'(eo));
      @(posedge clk); #1;
   endtask

   function automatic logic [N-1:0] rnd();
      logic [N-1:0] v;
      for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] va [8];
      logic [N-1:0] vb [8];
      logic         vs [8];
      logic         vc [8];
      int           base;
      int           cyc;
      int           i;
      bit           acc;

      // Reset held with a valid operand presented.
      rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_out_valid", (N+1)'(out_valid), (N+1)'(0));
      check("rst_s", (N+1)'(s), (N+1)'(0));
      check("rst_cout", (N+1)'(cout), (N+1)'(0));
      check("rst_ovf", (N+1)'(ovf), (N+1)'(0));
      check("rst_in_ready", (N+1)'(in_ready), (N+1)'(1));
      @(posedge clk); #1;
      check("rst2_out_valid", (N+1)'(out_valid), (N+1)'(0));
      rst = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < S + 1; k++) begin
         @(posedge clk); #1;
         check("post_rst_quiet", (N+1)'(out_valid), (N+1)'(0));
      end

      // Directed vectors with literal expectations.
      do_single("full_ripple", '1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      do_single("sub_borrow", N'(5), N'(7), 1'b0, 1'b1, {{(N-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
      do_single("signed_ovf", {1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0,
                {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b1);
      do_single("stage_cross", {{(N-64){1'b0}}, {64{1'b1}}}, N'(1), 1'b0, 1'b0,
                {{(N-65){1'b0}}, 1'b1, {64{1'b0}}}, 1'b0, 1'b0);
      do_single("sub_cin_ignored", N'(10), N'(3), 1'b1, 1'b1, N'(7), 1'b1, 1'b0);
      do_single("sub_zero", '0, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      do_single("sub_min_ovf", {1'b1, {(N-1){1'b0}}}, N'(1), 1'b0, 1'b1,
                {1'b0, {(N-1){1'b1}}}, 1'b1, 1'b1);

      // Back-pressure: 8 back-to-back ops, out_ready low for cycles 5..7.
      for (int k = 0; k < 8; k++) begin
         va[k] = rnd(); vb[k] = rnd(); vs[k] = 1'($urandom); vc[k] = 1'($urandom);
      end
      base = nres; i = 0; cyc = 0;
      while ((nres - base) < 8 && cyc < 60) begin
         out_ready = !(cyc >= 5 && cyc <= 7);
         if (i < 8) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i]; cin = vc[i];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (cyc >= 5 && cyc <= 7) check("bp_in_ready_low", (N+1)'(in_ready), (N+1)'(0));
         @(posedge clk); #1;
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_accepted", (N+1)'(i), (N+1)'(8));
      check("bp_results", (N+1)'(nres - base), (N+1)'(8));

      // Reset mid-flight: three ops in, idle cycle, then two reset cycles.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; a = N'(k + 1); b = N'(100); sub = 1'b0; cin = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < S + 2; k++) begin
         check("flush_quiet", (N+1)'(out_valid), (N+1)'(0));
         @(posedge clk); #1;
      end
      do_single("after_flush", N'(1000), N'(234), 1'b1, 1'b0, N'(1235), 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", (N+1)'(q.size()), (N+1)'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
